// File: rtl/code_lock_pkg.sv
// rtl/code_lock_pkg.sv - shared state type and default constants for the code lock
package code_lock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ENTRY   = 2'd1,
      ST_OPEN    = 2'd2,
      ST_LOCKOUT = 2'd3
   } lock_state_t;

   localparam int DEF_CODE_LEN  = 4;
   localparam int DEF_SYM_W     = 2;
   localparam int DEF_TIMEOUT   = 15;
   localparam int DEF_MAX_TRIES = 3;
   localparam int DEF_OPEN_TIME = 8;
   localparam int DEF_LOCK_TIME = 32;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter with zero flag, saturating at zero
module lock_timer #(
   parameter int W = 6
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - keypad code lock with entry timeout, open window and lockout
module code_lock_ctrl
   import code_lock_pkg::*;
#(
   parameter int CODE_LEN  = DEF_CODE_LEN,
   parameter int SYM_W     = DEF_SYM_W,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int MAX_TRIES = DEF_MAX_TRIES,
   parameter int OPEN_TIME = DEF_OPEN_TIME,
   parameter int LOCK_TIME = DEF_LOCK_TIME
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                sym_valid,
   input  logic [SYM_W-1:0]                    sym,
   input  logic [CODE_LEN*SYM_W-1:0]           code,
   output logic                                unlock,
   output logic                                err,
   output logic                                locked_out,
   output logic [$clog2(MAX_TRIES+1)-1:0]      tries
);

   localparam int TRW = $clog2(MAX_TRIES + 1);
   localparam int TMW = $clog2(max3(TIMEOUT, OPEN_TIME, LOCK_TIME) + 1);
   localparam int IXW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

   lock_state_t                      r_state;
   logic [CODE_LEN-1:0][SYM_W-1:0]   r_code;
   logic [IXW-1:0]                   r_idx;
   logic                             r_mis;
   logic                             r_unlock;
   logic                             r_err;
   logic                             r_locked;
   logic [TRW-1:0]                   r_tries;

   logic                             w_sym_mis;
   logic                             w_last;
   logic                             w_done;
   logic                             w_timeout;
   logic                             w_bad;
   logic                             w_pass;
   logic                             w_fail;
   logic                             w_to_lock;
   logic [TRW-1:0]                   w_tries_inc;
   logic                             w_tmr_load;
   logic                             w_tmr_en;
   logic                             w_tmr_zero;
   logic [TMW-1:0]                   w_tmr_val;

   // Verdict is only formed on the last symbol or on an idle timeout
   always_comb begin
      w_sym_mis   = (sym != r_code[r_idx]);
      w_last      = (r_idx == IXW'(CODE_LEN - 1));
      w_bad       = r_mis | w_sym_mis;
      w_done      = (r_state == ST_ENTRY) && sym_valid && w_last;
      w_timeout   = (r_state == ST_ENTRY) && !sym_valid && w_tmr_zero;
      w_pass      = w_done && !w_bad;
      w_fail      = (w_done && w_bad) || w_timeout;
      w_tries_inc = r_tries + 1'b1;
      w_to_lock   = w_fail && (w_tries_inc == TRW'(MAX_TRIES));
   end

   // One timer serves the inter-symbol timeout, the open window and the lockout
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_en   = 1'b0;
      w_tmr_val  = TMW'(TIMEOUT - 1);
      case (r_state)
         ST_IDLE: begin
            w_tmr_load = sym_valid;
         end
         ST_ENTRY: begin
            if (w_pass) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TMW'(OPEN_TIME - 1);
            end else if (w_to_lock) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = TMW'(LOCK_TIME - 1);
            end else if (sym_valid) begin
               w_tmr_load = 1'b1;
            end else begin
               w_tmr_en   = 1'b1;
            end
         end
         default: begin
            w_tmr_en = 1'b1;
         end
      endcase
   end

   lock_timer #(
      .W (TMW)
   ) u_timer (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (w_tmr_en),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_code   <= '0;
         r_idx    <= '0;
         r_mis    <= 1'b0;
         r_unlock <= 1'b0;
         r_err    <= 1'b0;
         r_locked <= 1'b0;
         r_tries  <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sym_valid) begin
                  r_code  <= code;
                  r_mis   <= (sym != code[SYM_W-1:0]);
                  r_idx   <= IXW'(1);
                  r_state <= ST_ENTRY;
               end
            end
            ST_ENTRY: begin
               if (w_pass) begin
                  r_unlock <= 1'b1;
                  r_tries  <= '0;
                  r_state  <= ST_OPEN;
               end else if (w_fail) begin
                  r_err   <= 1'b1;
                  r_tries <= w_tries_inc;
                  if (w_to_lock) begin
                     r_locked <= 1'b1;
                     r_state  <= ST_LOCKOUT;
                  end else begin
                     r_state  <= ST_IDLE;
                  end
               end else if (sym_valid) begin
                  r_mis <= w_bad;
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_OPEN: begin
               if (w_tmr_zero) begin
                  r_unlock <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            ST_LOCKOUT: begin
               if (w_tmr_zero) begin
                  r_locked <= 1'b0;
                  r_tries  <= '0;
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign unlock     = r_unlock;
   assign err        = r_err;
   assign locked_out = r_locked;
   assign tries      = r_tries;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb/tb_code_lock_ctrl.sv - vector table, directed sequences and random stimulus for code_lock_ctrl
module tb_code_lock_ctrl;

   localparam int CODE_LEN  = 4;
   localparam int TIMEOUT   = 15;
   localparam int MAX_TRIES = 3;
   localparam int OPEN_TIME = 8;
   localparam int LOCK_TIME = 32;
   localparam int C         = 'h36;
   localparam int W         = 'h76;

   logic       clk;
   logic       reset;
   logic       sym_valid;
   logic [1:0] sym;
   logic [7:0] code;
   logic       unlock;
   logic       err;
   logic       locked_out;
   logic [1:0] tries;

   int total = 0;
   int bad   = 0;

   code_lock_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .sym_valid  (sym_valid),
      .sym        (sym),
      .code       (code),
      .unlock     (unlock),
      .err        (err),
      .locked_out (locked_out),
      .tries      (tries)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int rn; int v; int s; int c;
      int ul; int er; int lo; int tr;
   } vec_t;
   vec_t tab[$];

   int m_tries, m_open, m_lock, m_idle, m_err, m_snap;
   int m_q[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void add(input int rn, input int v, input int s, input int c,
                               input int ul, input int er, input int lo, input int tr);
      vec_t e;
      e.rn = rn; e.v = v; e.s = s; e.c = c;
      e.ul = ul; e.er = er; e.lo = lo; e.tr = tr;
      tab.push_back(e);
   endfunction

   function automatic void model_reset();
      m_tries = 0; m_open = 0; m_lock = 0; m_idle = 0; m_err = 0; m_snap = 0;
      m_q.delete();
   endfunction

   // Behavioural reference: attempt = list of entered symbols vs a snapshot of the code
   function automatic void model_step(input int v, input int s, input int c);
      int pass, fail;
      pass = 0; fail = 0; m_err = 0;
      if (m_open > 0) begin
         m_open--;
      end else if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_tries = 0;
      end else if (v != 0) begin
         if (m_q.size() == 0) m_snap = c;
         m_q.push_back(s);
         m_idle = 0;
         if (m_q.size() == CODE_LEN) begin
            pass = 1;
            for (int i = 0; i < CODE_LEN; i++)
               if (m_q[i] != ((m_snap >> (2 * i)) & 3)) pass = 0;
            fail = 1 - pass;
            m_q.delete();
         end
      end else if (m_q.size() > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            fail = 1;
            m_q.delete();
         end
      end
      if (pass != 0) begin
         m_tries = 0;
         m_open  = OPEN_TIME;
      end
      if (fail != 0) begin
         m_err = 1;
         m_tries++;
         if (m_tries == MAX_TRIES) m_lock = LOCK_TIME;
      end
   endfunction

   task automatic drive(input int v, input int s, input int c, input int rn);
      sym_valid = v[0];
      sym       = 2'(s);
      code      = 8'(c);
      reset     = rn[0];
      if (rn == 0) model_reset();
   endtask

   task automatic advance(input int v, input int s, input int c, input int rn);
      @(posedge clk);
      if (rn != 0) model_step(v, s, c);
      #1;
   endtask

   task automatic step(input int v, input int s, input int c, input int rn);
      drive(v, s, c, rn);
      @(negedge clk);
      chk("unlock", int'(unlock), int'(m_open > 0));
      chk("err", int'(err), m_err);
      chk("locked_out", int'(locked_out), int'(m_lock > 0));
      chk("tries", int'(tries), m_tries);
      advance(v, s, c, rn);
   endtask

   task automatic enter(input int seq, input int c);
      for (int i = 0; i < CODE_LEN; i++) step(1, (seq >> (2 * i)) & 3, c, 1);
   endtask

   initial begin
      int rv, rs, rc, rrn, quiet, k;
      model_reset();
      drive(0, 0, C, 0);

      add(0,0,0,C, 0,0,0,0);
      add(1,1,2,C, 0,0,0,0); add(1,1,1,C, 0,0,0,0); add(1,1,3,C, 0,0,0,0); add(1,1,0,C, 0,0,0,0);
      repeat (7) add(1,0,0,C, 1,0,0,0);
      add(1,1,2,C, 1,0,0,0);
      add(1,0,0,C, 0,0,0,0); add(1,0,0,C, 0,0,0,0);
      add(1,1,2,C, 0,0,0,0); add(1,1,1,C, 0,0,0,0); add(1,1,3,C, 0,0,0,0); add(1,1,1,C, 0,0,0,0);
      add(1,0,0,C, 0,1,0,1); add(1,0,0,C, 0,0,0,1);
      add(1,1,2,C, 0,0,0,1); add(1,1,1,C, 0,0,0,1);
      repeat (15) add(1,0,0,C, 0,0,0,1);
      add(1,0,0,C, 0,1,0,2); add(1,0,0,C, 0,0,0,2);
      add(1,1,2,C, 0,0,0,2); add(1,1,1,0, 0,0,0,2); add(1,1,3,0, 0,0,0,2); add(1,1,0,0, 0,0,0,2);
      repeat (8) add(1,0,0,0, 1,0,0,0);
      add(1,0,0,C, 0,0,0,0);

      for (int i = 0; i < tab.size(); i++) begin
         drive(tab[i].v, tab[i].s, tab[i].c, tab[i].rn);
         @(negedge clk);
         chk($sformatf("vec%0d.unlock", i), int'(unlock), tab[i].ul);
         chk($sformatf("vec%0d.err", i), int'(err), tab[i].er);
         chk($sformatf("vec%0d.locked_out", i), int'(locked_out), tab[i].lo);
         chk($sformatf("vec%0d.tries", i), int'(tries), tab[i].tr);
         advance(tab[i].v, tab[i].s, tab[i].c, tab[i].rn);
      end

      // Three failures, correct code ignored during lockout
      enter(W, C); step(0, 0, C, 1);
      enter(W, C); step(0, 0, C, 1);
      enter(W, C);
      chk("lock_entry.locked_out", int'(locked_out), 1);
      chk("lock_entry.err", int'(err), 1);
      chk("lock_entry.tries", int'(tries), MAX_TRIES);
      enter(C, C);
      repeat (30) step(0, 0, C, 1);
      chk("lock_exit.locked_out", int'(locked_out), 0);
      chk("lock_exit.tries", int'(tries), 0);
      chk("lock_exit.unlock", int'(unlock), 0);
      step(0, 0, C, 1);

      // Reset while open
      enter(C, C);
      chk("open.unlock", int'(unlock), 1);
      repeat (3) step(0, 0, C, 1);
      step(0, 0, C, 0);

      // Reset mid-entry, then a lone 0 must not unlock
      step(1, 2, C, 1); step(1, 1, C, 1); step(1, 3, C, 1);
      step(0, 0, C, 0);
      step(1, 0, C, 1);
      repeat (20) step(0, 0, C, 1);

      // Reset during lockout discards it
      repeat (3) begin enter(W, C); step(0, 0, C, 1); end
      repeat (5) step(0, 0, C, 1);
      step(0, 0, C, 0);
      step(0, 0, C, 1);
      enter(C, C);
      chk("post_lock_reset.unlock", int'(unlock), 1);
      repeat (10) step(0, 0, C, 1);

      quiet = 0;
      rc = C;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 99) < 3) quiet = 1 - quiet;
         if ($urandom_range(0, 49) == 0) rc = int'($urandom_range(0, 255));
         rrn = ($urandom_range(0, 199) == 0) ? 0 : 1;
         rv  = ($urandom_range(0, 99) < ((quiet != 0) ? 2 : 60)) ? 1 : 0;
         k   = m_q.size();
         if ($urandom_range(0, 3) != 0)
            rs = (k == 0) ? (rc & 3) : ((m_snap >> (2 * k)) & 3);
         else
            rs = int'($urandom_range(0, 3));
         step(rv, rs, rc, rrn);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 SHALL have parameter CODE_LEN, default 4, meaning number of symbols per code.
REQ-002 SHALL have parameter SYM_W, default 2, meaning symbol width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum idle cycles between symbols during entry.
REQ-004 SHALL have parameter MAX_TRIES, default 3, meaning consecutive failures that trigger lockout.
REQ-005 SHALL have parameter OPEN_TIME, default 8, meaning cycles unlock stays asserted.
REQ-006 SHALL have parameter LOCK_TIME, default 32, meaning lockout duration in cycles.
REQ-007 SHALL have port clk, input, 1 bit, meaning the single clock, rising-edge active.
REQ-008 SHALL have port reset, input, 1 bit, meaning asynchronous active-low reset.
REQ-009 SHALL have port sym_valid, input, 1 bit, meaning sym carries a new symbol this cycle.
REQ-010 SHALL have port sym, input, SYM_W bits, meaning the entered symbol.
REQ-011 SHALL have port code, input, CODE_LEN*SYM_W bits, meaning the secret code, with symbol i at bits [i*SYM_W +: SYM_W] and symbol 0 entered first.
REQ-012 SHALL have port unlock, output, 1 bit, meaning the resource is open.
REQ-013 SHALL have port err, output, 1 bit, meaning a one-cycle pulse on a failed attempt.
REQ-014 SHALL have port locked_out, output, 1 bit, meaning lockout is active and input is ignored.
REQ-015 SHALL have port tries, output, $clog2(MAX_TRIES+1) bits, meaning the count of consecutive failures.

Function
REQ-016 SHALL implement the states IDLE, ENTRY, OPEN and LOCKOUT.
REQ-017 In IDLE, sym_valid SHALL register the code, compare sym to code symbol 0, set the index to 1 and move to ENTRY.
REQ-018 In ENTRY, each sym_valid SHALL compare sym to the registered symbol at the current index, OR any mismatch into a sticky flag, increment the index and reload the timeout counter.
REQ-019 A change on code during ENTRY SHALL NOT affect the attempt in progress.
REQ-020 A wrong symbol SHALL NOT abort entry early; the verdict is given only after all CODE_LEN symbols.
REQ-021 If the last symbol (index CODE_LEN-1) is accepted in cycle N with no mismatch, unlock SHALL be 1 from N+1 for exactly OPEN_TIME cycles, tries SHALL clear to 0 and the state SHALL be OPEN.
REQ-022 If the last symbol is accepted in cycle N with a mismatch, err SHALL be 1 in N+1 only and tries SHALL increment.
REQ-023 After a mismatch, if the new value of tries equals MAX_TRIES, the state SHALL be LOCKOUT; otherwise it SHALL be IDLE.
REQ-024 If TIMEOUT consecutive cycles pass in ENTRY without sym_valid, the attempt SHALL be treated as a failure with the same err, tries and lockout behaviour as a mismatch.
REQ-025 In LOCKOUT, locked_out SHALL be 1 for exactly LOCK_TIME cycles; then tries SHALL clear to 0 and the state SHALL return to IDLE.
REQ-026 In OPEN and LOCKOUT, sym_valid SHALL be ignored, and a symbol given on the exit cycle SHALL NOT start an entry.
REQ-027 When OPEN ends, the state SHALL be IDLE and unlock SHALL be 0 in the following cycle.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-029 reset low SHALL immediately force state IDLE, unlock 0, err 0, locked_out 0, tries 0, and clear the index, mismatch flag and all counters.
REQ-030 Reset asserted during ENTRY, OPEN or LOCKOUT SHALL discard all progress, including lockout.
REQ-031 Reset deassertion SHALL take effect at the next rising edge of clk.

Structure
REQ-032 A shared package code_lock_pkg SHALL hold the state enum type lock_state_t and the default parameter constants.
REQ-033 One sub-module, lock_timer, SHALL provide a loadable down-counter with load, load value, enable and zero flag, shared by the timeout, OPEN and LOCKOUT timing.
REQ-034 The total RTL SHALL be 120-400 lines.

Verification (defaults, code = 8'b00_11_01_10, so the entry order is 2,1,3,0)
REQ-035 Enter 2,1,3,0 on consecutive cycles -> unlock=1 for 8 cycles starting the cycle after the 0, tries=0, err never asserted.
REQ-036 Enter 2,1,3,1 -> err pulses one cycle, tries=1, unlock stays 0, state returns to IDLE.
REQ-037 Give three wrong codes in a row -> third err, locked_out=1 for 32 cycles; a correct code entered during lockout -> no unlock; tries=0 after lockout.
REQ-038 Enter 2,1, then hold sym_valid low for 15 cycles -> err pulse, tries=1; a following correct code entry -> unlock.
REQ-039 Enter 2,1,3, then drive reset low for 1 cycle -> all outputs 0 immediately; 0 alone after release -> no unlock.
REQ-040 Enter 2, then change code mid-entry, then 1,3,0 -> unlock, proving the code was latched.
